seven_seg_scan_ctrl: RTL and testbench



---
 rtl/seven_seg_scan_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed 7-segment scanner for NUM_DIGITS common-select digits.
// Each digit slot has three phases: dead time (BLANK), a lit window whose
// length sets the brightness (ON), and the dark rest of the slot (OFF).
// Display data moves to the active set only at frame boundaries, so a frame
// never mixes old and new values. Leading-zero blanking, per-digit decimal
// points and per-digit blink are applied on top of the hex glyphs.
// Every output register is loaded from the next-cycle slot state. This keeps
// the pins in step with the internal counters.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS     = 6,
  parameter int CLK_FREQ       = 50_000_000,
  parameter int SCAN_FREQ      = 200,
  parameter int BLANK_CYCLES   = 500,
  parameter int BLINK_DIV      = 25_000_000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] show_data,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lz_blank_en,
  input  logic [3:0]              brightness,
  input  logic                    update,
  output logic [7:0]              seven_tube_seg,
  output logic [NUM_DIGITS-1:0]   seven_tube_sel,
  output logic                    frame_done
);

  localparam int DIGIT_CYCLES = CLK_FREQ / (SCAN_FREQ * NUM_DIGITS);
  localparam int SPAN         = DIGIT_CYCLES - BLANK_CYCLES;
  localparam int CW           = $clog2(DIGIT_CYCLES + 1);
  localparam int PW           = CW + 5;
  localparam int DW           = $clog2(NUM_DIGITS);
  localparam int BW           = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CW-1:0]         LAST_CNT   = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0]         BLANK_LEN  = CW'(BLANK_CYCLES);
  localparam logic [CW:0]           BLANK_LENW = (CW+1)'(BLANK_CYCLES);
  localparam logic [DW-1:0]         LAST_DIGIT = DW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0]         BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [7:0]            SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] SEL_OFF    = (SEL_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                       : {NUM_DIGITS{1'b0}};
  localparam logic [NUM_DIGITS-1:0] SEL_ONE    = NUM_DIGITS'(1);

  // Illegal parameter sets are rejected at elaboration.
  if ((NUM_DIGITS < 2) || (NUM_DIGITS > 8)) begin : g_bad_digits
    $error("seven_seg_scan_ctrl: NUM_DIGITS must be 2..8");
  end
  if (DIGIT_CYCLES < BLANK_CYCLES + 2) begin : g_bad_timing
    $error("seven_seg_scan_ctrl: DIGIT_CYCLES must be >= BLANK_CYCLES + 2");
  end
  if (BLINK_DIV < 1) begin : g_bad_blink
    $error("seven_seg_scan_ctrl: BLINK_DIV must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_BLANK = 2'd0,
    ST_ON    = 2'd1,
    ST_OFF   = 2'd2
  } slot_state_e;

  localparam slot_state_e SLOT_START = (BLANK_CYCLES == 0) ? ST_ON : ST_BLANK;

  // Active-high segment pattern {g,f,e,d,c,b,a} for a hex nibble.
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      4'hF: g = 7'h71;
      default: g = 7'h00;
    endcase
    return g;
  endfunction

  // ON window length for a brightness level, never shorter than one cycle.
  function automatic logic [CW-1:0] on_len_calc(input logic [3:0] level);
    logic [PW-1:0] prod;
    logic [CW-1:0] len;
    prod = PW'(SPAN) * (PW'(level) + PW'(1));
    prod = prod >> 4;
    if (prod == PW'(0)) begin
      len = CW'(1);
    end else begin
      len = CW'(prod);
    end
    return len;
  endfunction

  slot_state_e state_r, state_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic [DW-1:0] digit_r, digit_nxt_s;
  logic [CW-1:0] on_len_r, on_len_nxt_s;
  logic          slot_end_s, frame_end_s, on_end_s, frame_done_nxt_s;

  logic [4*NUM_DIGITS-1:0] act_data_r, act_data_nxt_s, pend_data_r, pend_data_nxt_s;
  logic [NUM_DIGITS-1:0]   act_dp_r, act_dp_nxt_s, pend_dp_r, pend_dp_nxt_s;
  logic [NUM_DIGITS-1:0]   act_blink_r, act_blink_nxt_s, pend_blink_r, pend_blink_nxt_s;

  logic [BW-1:0] blink_cnt_r, blink_cnt_nxt_s;
  logic          blink_phase_r, blink_phase_nxt_s;

  logic [NUM_DIGITS-1:0] lz_mask_s;
  logic                  lead_zero_s;
  logic [3:0]            cur_nib_s;
  logic                  cur_dp_s, cur_blink_s, cur_blank_s;
  logic [7:0]            seg_hi_s;
  logic [NUM_DIGITS-1:0] sel_hi_s;
  logic [7:0]            seg_r;
  logic [NUM_DIGITS-1:0] sel_r;
  logic                  frame_done_r;

  // Slot counter, digit index and per-slot brightness latch.
  always_comb begin
    slot_end_s   = (cnt_r == LAST_CNT);
    frame_end_s  = slot_end_s && (digit_r == LAST_DIGIT);
    cnt_nxt_s    = slot_end_s ? {CW{1'b0}} : (cnt_r + CW'(1));
    digit_nxt_s  = digit_r;
    if (slot_end_s) begin
      digit_nxt_s = (digit_r == LAST_DIGIT) ? {DW{1'b0}} : (digit_r + DW'(1));
    end else begin
      digit_nxt_s = digit_r;
    end
    // Brightness is captured during the first cycle of the slot.
    on_len_nxt_s = (cnt_r == {CW{1'b0}}) ? on_len_calc(brightness) : on_len_r;
    on_end_s     = ({1'b0, cnt_nxt_s} >= (BLANK_LENW + {1'b0, on_len_nxt_s}));
    frame_done_nxt_s = (cnt_nxt_s == LAST_CNT) && (digit_nxt_s == LAST_DIGIT);
  end

  // Slot phase sequencing: BLANK -> ON -> OFF, restarting at every slot end.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_BLANK: begin
        if (slot_end_s) begin
          state_nxt_s = SLOT_START;
        end else if (cnt_nxt_s >= BLANK_LEN) begin
          state_nxt_s = ST_ON;
        end else begin
          state_nxt_s = ST_BLANK;
        end
      end
      ST_ON: begin
        if (slot_end_s) begin
          state_nxt_s = SLOT_START;
        end else if (on_end_s) begin
          state_nxt_s = ST_OFF;
        end else begin
          state_nxt_s = ST_ON;
        end
      end
      ST_OFF: begin
        if (slot_end_s) begin
          state_nxt_s = SLOT_START;
        end else begin
          state_nxt_s = ST_OFF;
        end
      end
      default: state_nxt_s = ST_BLANK;
    endcase
  end

  // Pending/active data: an update coinciding with the frame end bypasses pending.
  always_comb begin
    if (update) begin
      pend_data_nxt_s  = show_data;
      pend_dp_nxt_s    = dp_mask;
      pend_blink_nxt_s = blink_mask;
    end else begin
      pend_data_nxt_s  = pend_data_r;
      pend_dp_nxt_s    = pend_dp_r;
      pend_blink_nxt_s = pend_blink_r;
    end
    if (frame_end_s) begin
      act_data_nxt_s  = pend_data_nxt_s;
      act_dp_nxt_s    = pend_dp_nxt_s;
      act_blink_nxt_s = pend_blink_nxt_s;
    end else begin
      act_data_nxt_s  = act_data_r;
      act_dp_nxt_s    = act_dp_r;
      act_blink_nxt_s = act_blink_r;
    end
  end

  // Free-running blink divider toggling the blink phase.
  always_comb begin
    if (blink_cnt_r == BLINK_LAST) begin
      blink_cnt_nxt_s   = {BW{1'b0}};
      blink_phase_nxt_s = ~blink_phase_r;
    end else begin
      blink_cnt_nxt_s   = blink_cnt_r + BW'(1);
      blink_phase_nxt_s = blink_phase_r;
    end
  end

  // Glyph selection, leading-zero blanking and digit select for the next cycle.
  always_comb begin
    lead_zero_s = 1'b1;
    lz_mask_s   = {NUM_DIGITS{1'b0}};
    cur_nib_s   = 4'h0;
    cur_dp_s    = 1'b0;
    cur_blink_s = 1'b0;
    cur_blank_s = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      lead_zero_s  = lead_zero_s && (act_data_nxt_s[4*(NUM_DIGITS-1-i) +: 4] == 4'h0);
      lz_mask_s[i] = lz_blank_en && lead_zero_s && (i != NUM_DIGITS - 1);
      if (digit_nxt_s == DW'(i)) begin
        cur_nib_s   = act_data_nxt_s[4*(NUM_DIGITS-1-i) +: 4];
        cur_dp_s    = act_dp_nxt_s[i];
        cur_blink_s = act_blink_nxt_s[i];
        cur_blank_s = lz_mask_s[i];
      end else begin
        cur_nib_s   = cur_nib_s;
      end
    end
    if (state_nxt_s == ST_ON) begin
      seg_hi_s = {cur_dp_s, (cur_blank_s ? 7'h00 : hex_glyph(cur_nib_s))};
      if (blink_phase_nxt_s && cur_blink_s) begin
        sel_hi_s = {NUM_DIGITS{1'b0}};
      end else begin
        sel_hi_s = SEL_ONE << digit_nxt_s;
      end
    end else begin
      seg_hi_s = 8'h00;
      sel_hi_s = {NUM_DIGITS{1'b0}};
    end
  end

  // Slot phase register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_BLANK;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Slot counter, digit index and brightness latch registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= {CW{1'b0}};
      digit_r  <= {DW{1'b0}};
      on_len_r <= {CW{1'b0}};
    end else begin
      cnt_r    <= cnt_nxt_s;
      digit_r  <= digit_nxt_s;
      on_len_r <= on_len_nxt_s;
    end
  end

  // Pending and active display data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_data_r  <= {(4*NUM_DIGITS){1'b0}};
      pend_dp_r    <= {NUM_DIGITS{1'b0}};
      pend_blink_r <= {NUM_DIGITS{1'b0}};
      act_data_r   <= {(4*NUM_DIGITS){1'b0}};
      act_dp_r     <= {NUM_DIGITS{1'b0}};
      act_blink_r  <= {NUM_DIGITS{1'b0}};
    end else begin
      pend_data_r  <= pend_data_nxt_s;
      pend_dp_r    <= pend_dp_nxt_s;
      pend_blink_r <= pend_blink_nxt_s;
      act_data_r   <= act_data_nxt_s;
      act_dp_r     <= act_dp_nxt_s;
      act_blink_r  <= act_blink_nxt_s;
    end
  end

  // Blink divider registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_r   <= {BW{1'b0}};
      blink_phase_r <= 1'b0;
    end else begin
      blink_cnt_r   <= blink_cnt_nxt_s;
      blink_phase_r <= blink_phase_nxt_s;
    end
  end

  // Pin registers with output polarity applied; seg and sel move together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_r        <= SEG_OFF;
      sel_r        <= SEL_OFF;
      frame_done_r <= 1'b0;
    end else begin
      seg_r        <= seg_hi_s ^ SEG_OFF;
      sel_r        <= sel_hi_s ^ SEL_OFF;
      frame_done_r <= frame_done_nxt_s;
    end
  end

  assign seven_tube_seg = seg_r;
  assign seven_tube_sel = sel_r;
  assign frame_done     = frame_done_r;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl: 4 digits, 30-cycle slots,
// 120-cycle frames, 2 blank cycles, blink half-period 240 cycles, active-low pins.
// Stimulus queues cycle-tagged expected pin values; a monitor compares them.
module tb_seven_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] show_data = 16'h0000;
  logic [3:0]  dp_mask = 4'b0000;
  logic [3:0]  blink_mask = 4'b0000;
  logic        lz_blank_en = 1'b0;
  logic [3:0]  brightness = 4'd15;
  logic        update = 1'b0;
  logic [7:0]  seven_tube_seg;
  logic [3:0]  seven_tube_sel;
  logic        frame_done;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS(4), .CLK_FREQ(1200), .SCAN_FREQ(10), .BLANK_CYCLES(2),
    .BLINK_DIV(240), .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .show_data(show_data), .dp_mask(dp_mask),
    .blink_mask(blink_mask), .lz_blank_en(lz_blank_en), .brightness(brightness),
    .update(update), .seven_tube_seg(seven_tube_seg), .seven_tube_sel(seven_tube_sel),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Cycle index since the last reset release (held at 0 during reset).
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    int         cyc;
    logic [3:0] sel;
    logic [7:0] seg;
    logic       fd;
  } exp_t;

  exp_t sbq[$];
  int   total_cnt = 0;
  int   pass_cnt  = 0;

  task automatic push_one(input int c, input logic [3:0] sel, input logic [7:0] seg, input logic fd);
    exp_t e;
    e.cyc = c; e.sel = sel; e.seg = seg; e.fd = fd;
    sbq.push_back(e);
  endtask

  // Expected pins for a whole frame: g0..g3 are hand-computed active-low glyphs.
  task automatic push_frame(input int f, input logic [7:0] g0, input logic [7:0] g1,
                            input logic [7:0] g2, input logic [7:0] g3,
                            input int on_len, input logic [3:0] blink);
    logic [7:0] g [4];
    g[0] = g0; g[1] = g1; g[2] = g2; g[3] = g3;
    for (int c = 0; c < 120; c++) begin
      int d, s, k;
      logic on, hide;
      logic [3:0] sel;
      d = c / 30; s = c % 30; k = 120 * f + c;
      on = (s >= 2) && (s < 2 + on_len);
      hide = blink[d] && (((k / 240) % 2) == 1);
      sel = 4'hF;
      if (on && !hide) sel[d] = 1'b0;
      push_one(k, sel, on ? g[d] : 8'hFF, (c == 119));
    end
  endtask

  task automatic goto_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic pulse_update();
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
  endtask

  // Monitor: compares every queued expectation whose cycle has arrived.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        e = sbq.pop_front();
        total_cnt++;
        if (e.cyc == cyc && seven_tube_sel === e.sel && seven_tube_seg === e.seg &&
            frame_done === e.fd) begin
          pass_cnt++;
        end else begin
          $display("FAIL scan cyc=%0d(tag %0d) got sel=%h seg=%h fd=%b want sel=%h seg=%h fd=%b",
                   cyc, e.cyc, seven_tube_sel, seven_tube_seg, frame_done, e.sel, e.seg, e.fd);
        end
      end
    end
  end

  initial begin
    // Reset state.
    @(negedge clk);
    push_one(0, 4'hF, 8'hFF, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Frame 0: active data still zero; frames after carry the scheduled changes.
    push_frame(0,  8'hC0, 8'hC0, 8'hC0, 8'hC0, 28, 4'b0000);
    push_frame(1,  8'hF9, 8'hA4, 8'h88, 8'h8E, 28, 4'b0000);
    push_frame(2,  8'hF9, 8'hA4, 8'h88, 8'h8E, 14, 4'b0000);
    push_frame(3,  8'hF9, 8'hA4, 8'h88, 8'h8E, 1,  4'b0000);
    push_frame(4,  8'hFF, 8'h7F, 8'hFF, 8'h92, 28, 4'b0000);
    push_frame(5,  8'hC0, 8'h40, 8'hC0, 8'h92, 28, 4'b0000);
    push_frame(6,  8'h90, 8'h90, 8'h90, 8'h90, 28, 4'b0000);
    push_frame(7,  8'hB0, 8'h86, 8'h92, 8'hC6, 28, 4'b0000);
    for (int f = 8; f <= 12; f++) begin
      push_frame(f, 8'hB0, 8'h86, 8'h92, 8'hC6, 28, 4'b0100);
    end

    goto_cyc(10);  show_data = 16'h12AF; pulse_update();
    goto_cyc(215); brightness = 4'd7;
    goto_cyc(335); brightness = 4'd0;
    goto_cyc(455); brightness = 4'd15; lz_blank_en = 1'b1;
    show_data = 16'h0005; dp_mask = 4'b0010; pulse_update();
    goto_cyc(575); lz_blank_en = 1'b0;
    goto_cyc(610); show_data = 16'h9999; dp_mask = 4'b0000; pulse_update();
    goto_cyc(839); show_data = 16'h3E5C; pulse_update();
    goto_cyc(850); blink_mask = 4'b0100; pulse_update();

    // Asynchronous reset in the middle of digit 1's ON window.
    goto_cyc(1595);
    push_one(0, 4'hF, 8'hFF, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    push_frame(0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 28, 4'b0000);

    for (int i = 0; i < 400 && sbq.size() > 0; i++) @(negedge clk);
    #2;
    if (sbq.size() > 0) begin
      total_cnt++;
      $display("FAIL drain pending=%0d want 0", sbq.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
